// File: rtl/prog_loader_pkg.sv
// Shared types and widths for the program loader.
// PROG_LOADER_CHECKSUM_EN adds the CHECK state.
package prog_loader_pkg;

    localparam int ADDR_W = 4;
    localparam int DATA_W = 8;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LOAD   = 2'd1,
`ifdef PROG_LOADER_CHECKSUM_EN
        ST_CHECK  = 2'd2,
`endif
        ST_FINISH = 2'd3
    } state_t;

endpackage

// File: rtl/prog_loader_cksum.sv
// 8-bit running-sum accumulator with clear, add and zero flag.
// Only instantiated when PROG_LOADER_CHECKSUM_EN is defined.
module prog_loader_cksum
    import prog_loader_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              clear,
    input  logic              add,
    input  logic [DATA_W-1:0] data,
    output logic              zero
);

    logic [DATA_W-1:0] sum;

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            sum <= '0;
        end else if (add) begin
            sum <= sum + data;
        end
    end

    assign zero = (sum == '0);

endmodule

// File: rtl/prog_loader.sv
// Streams LEN program bytes into RAM while holding the CPU.
// PROG_LOADER_CHECKSUM_EN: trailing checksum byte, sticky err.
module prog_loader
    import prog_loader_pkg::*;
#(
    parameter int LEN = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [DATA_W-1:0] wr_data,
    output logic              cpu_hold,
    output logic              busy,
    output logic              done,
    output logic              err
);

    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(LEN - 1);

    state_t            state;
    logic [ADDR_W-1:0] cnt;
    logic              accept;

    assign accept = in_valid & in_ready;

`ifdef PROG_LOADER_CHECKSUM_EN
    logic ck_clear;
    logic ck_zero;

    assign ck_clear = (state == ST_IDLE) && start;

    prog_loader_cksum u_cksum (
        .clk   (clk),
        .reset (reset),
        .clear (ck_clear),
        .add   (accept),
        .data  (in_data),
        .zero  (ck_zero)
    );

    // Sum settles in FINISH, so err rises together with done.
    always_ff @(posedge clk) begin
        if (reset || ck_clear) begin
            err <= 1'b0;
        end else if (state == ST_FINISH && !ck_zero) begin
            err <= 1'b1;
        end
    end
`else
    assign err = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= ST_IDLE;
            cnt      <= '0;
            in_ready <= 1'b0;
            wr_en    <= 1'b0;
            wr_addr  <= '0;
            wr_data  <= '0;
            cpu_hold <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            wr_en <= 1'b0;
            done  <= 1'b0;
            unique case (state)
                ST_IDLE: begin
                    // Holding here drops cpu_hold one cycle after done.
                    cpu_hold <= start;
                    if (start) begin
                        state    <= ST_LOAD;
                        cnt      <= '0;
                        in_ready <= 1'b1;
                        busy     <= 1'b1;
                    end
                end
                ST_LOAD: begin
                    if (accept) begin
                        wr_en   <= 1'b1;
                        wr_addr <= cnt;
                        wr_data <= in_data;
                        if (cnt == LAST) begin
`ifdef PROG_LOADER_CHECKSUM_EN
                            state <= ST_CHECK;
`else
                            state    <= ST_FINISH;
                            in_ready <= 1'b0;
`endif
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                end
`ifdef PROG_LOADER_CHECKSUM_EN
                ST_CHECK: begin
                    if (accept) begin
                        state    <= ST_FINISH;
                        in_ready <= 1'b0;
                    end
                end
`endif
                ST_FINISH: begin
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_prog_loader.sv
// Randomized self-checking bench for prog_loader (LEN 16, 4, 2).
// Model: byte list, expected write list and handshake timing.
module tb_prog_loader;

    typedef struct {
        int addr;
        int data;
        int cyc;
    } wr_t;

    localparam int LENS [3] = '{16, 4, 2};
`ifdef PROG_LOADER_CHECKSUM_EN
    localparam int CK = 1;
`else
    localparam int CK = 0;
`endif

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic       in_valid = 1'b0;
    logic [7:0] in_data = '0;
    int         sel = 0;
    int         cyc = 0;

    logic       r  [3];
    logic       we [3];
    logic [3:0] wa [3];
    logic [7:0] wd [3];
    logic       ch [3];
    logic       bz [3];
    logic       dn [3];
    logic       er [3];

    for (genvar g = 0; g < 3; g++) begin : g_dut
        prog_loader #(.LEN(LENS[g])) dut (
            .clk      (clk),
            .reset    (reset),
            .start    (start && (sel == g)),
            .in_valid (in_valid && (sel == g)),
            .in_data  (in_data),
            .in_ready (r[g]),
            .wr_en    (we[g]),
            .wr_addr  (wa[g]),
            .wr_data  (wd[g]),
            .cpu_hold (ch[g]),
            .busy     (bz[g]),
            .done     (dn[g]),
            .err      (er[g])
        );
    end

    logic       c_in_ready, c_wr_en, c_cpu_hold, c_busy, c_done, c_err;
    logic [3:0] c_wr_addr;
    logic [7:0] c_wr_data;

    assign c_in_ready = r[sel];
    assign c_wr_en    = we[sel];
    assign c_wr_addr  = wa[sel];
    assign c_wr_data  = wd[sel];
    assign c_cpu_hold = ch[sel];
    assign c_busy     = bz[sel];
    assign c_done     = dn[sel];
    assign c_err      = er[sel];

    initial forever #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    int   checks = 0;
    int   errors = 0;

    wr_t  exp_q [$];
    wr_t  obs_q [$];
    logic done_log [4096];
    logic hold_log [4096];
    logic busy_log [4096];
    logic err_log  [4096];

    always @(negedge clk) begin
        wr_t w;
        if (c_wr_en === 1'b1) begin
            w.addr = int'(c_wr_addr);
            w.data = int'(c_wr_data);
            w.cyc  = cyc;
            obs_q.push_back(w);
        end
        done_log[cyc] <= c_done;
        hold_log[cyc] <= c_cpu_hold;
        busy_log[cyc] <= c_busy;
        err_log[cyc]  <= c_err;
    end

    // Reference model state
    bit         mdl_load = 0;
    int         mdl_len = 16;
    int         mdl_need = 16;
    int         mdl_cnt = 0;
    logic [7:0] mdl_sum = '0;
    int         last_acc = -10;
    int         start_cyc = 0;

    task automatic step(input bit sv, input bit vv, input logic [7:0] dd);
        wr_t w;
        start = sv;
        in_valid = vv;
        in_data = dd;
        @(negedge clk);
        checks++;
        if (c_in_ready !== mdl_load) begin
            errors++;
            $display("FAIL in_ready cyc %0d got %b exp %b",
                     cyc, c_in_ready, mdl_load);
        end
        if (mdl_load) begin
            checks++;
            if (c_busy !== 1'b1 || c_cpu_hold !== 1'b1) begin
                errors++;
                $display("FAIL busy_hold cyc %0d got %b%b exp 11",
                         cyc, c_busy, c_cpu_hold);
            end
        end
        if (vv && mdl_load) begin
            if (mdl_cnt < mdl_len) begin
                w.addr = mdl_cnt;
                w.data = int'(dd);
                w.cyc  = cyc + 1;
                exp_q.push_back(w);
            end
            mdl_sum = mdl_sum + dd;
            mdl_cnt++;
            if (mdl_cnt == mdl_need) begin
                mdl_load = 0;
                last_acc = cyc;
            end
        end else if (sv && !mdl_load && cyc >= last_acc + 2) begin
            mdl_load  = 1;
            mdl_cnt   = 0;
            mdl_sum   = '0;
            start_cyc = cyc;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic begin_session(input int s);
        sel = s;
        mdl_len = LENS[s];
        mdl_need = mdl_len + CK;
        exp_q.delete();
        obs_q.delete();
        step(1'b1, 1'b0, 8'h00);
    endtask

    task automatic drain(input string name);
        int   n;
        logic exp_err;
        repeat (4) step(1'b0, 1'b0, 8'h00);
        checks++;
        if (mdl_load) begin
            errors++;
            $display("FAIL %s session got incomplete exp complete", name);
        end else begin
            checks++;
            if (obs_q.size() != exp_q.size()) begin
                errors++;
                $display("FAIL %s wr_count got %0d exp %0d",
                         name, obs_q.size(), exp_q.size());
            end
            for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
                checks++;
                if (obs_q[i] != exp_q[i]) begin
                    errors++;
                    $display("FAIL %s wr%0d got a%0d d%0h c%0d exp a%0d d%0h c%0d",
                             name, i, obs_q[i].addr, obs_q[i].data, obs_q[i].cyc,
                             exp_q[i].addr, exp_q[i].data, exp_q[i].cyc);
                end
            end
            n = 0;
            for (int c = start_cyc + 1; c < cyc; c++) begin
                if (done_log[c] === 1'b1) n++;
            end
            checks++;
            if (n != 1 || done_log[last_acc + 2] !== 1'b1) begin
                errors++;
                $display("FAIL %s done got %0d pulses at_exp=%b exp 1 at cyc %0d",
                         name, n, done_log[last_acc + 2], last_acc + 2);
            end
            checks++;
            if (hold_log[last_acc + 2] !== 1'b1 ||
                hold_log[last_acc + 3] !== 1'b0) begin
                errors++;
                $display("FAIL %s cpu_hold_fall got %b%b exp 10", name,
                         hold_log[last_acc + 2], hold_log[last_acc + 3]);
            end
            if (exp_q.size() > 0) begin
                checks++;
                if (hold_log[exp_q[exp_q.size() - 1].cyc] !== 1'b1) begin
                    errors++;
                    $display("FAIL %s hold_last_write got 0 exp 1", name);
                end
            end
            checks++;
            if (busy_log[last_acc + 2] !== 1'b0) begin
                errors++;
                $display("FAIL %s busy_at_done got 1 exp 0", name);
            end
            exp_err = (CK == 1) && (mdl_sum != 8'h00);
            checks++;
            if (err_log[last_acc + 2] !== exp_err) begin
                errors++;
                $display("FAIL %s err got %b exp %b",
                         name, err_log[last_acc + 2], exp_err);
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            checks++;
            if ({r[i], we[i], wa[i], wd[i], ch[i], bz[i], dn[i], er[i]} !== '0) begin
                errors++;
                $display("FAIL reset_state dut%0d got %b%b%h%h%b%b%b%b exp 0",
                         i, r[i], we[i], wa[i], wd[i], ch[i], bz[i], dn[i], er[i]);
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_back_to_back();
        begin_session(0);
        for (int i = 0; i < 16; i++) step(1'b0, 1'b1, 8'(i));
        step(1'b0, 1'b1, 8'h88);
        drain("back_to_back");
    endtask

    task automatic test_gaps();
        begin_session(1);
        for (int i = 0; i < 12; i++) step(1'b0, (i % 2) == 0, 8'($urandom));
        drain("gaps_len4");
    endtask

    task automatic test_start_ignored();
        begin_session(0);
        for (int i = 0; i < 19; i++) step(i == 5, 1'b1, 8'($urandom));
        drain("start_ignored");
    endtask

    task automatic test_random();
        repeat (4) begin
            begin_session($urandom_range(0, 2));
            for (int i = 0; i < 200 && mdl_load; i++) begin
                step(mdl_load && ($urandom_range(0, 7) == 0),
                     1'($urandom_range(0, 1)), 8'($urandom));
            end
            step(1'b0, 1'b1, 8'($urandom));
            drain("random");
        end
    endtask

    task automatic test_abort();
        begin_session(0);
        while (mdl_cnt < 3) step(1'b0, 1'b1, 8'($urandom));
        reset = 1'b1;
        start = 1'b1;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        start = 1'b0;
        in_valid = 1'b0;
        mdl_load = 0;
        last_acc = -10;
        checks++;
        if ({c_in_ready, c_wr_en, c_wr_addr, c_wr_data, c_cpu_hold,
             c_busy, c_done, c_err} !== '0) begin
            errors++;
            $display("FAIL abort_state got %b%b%h%h%b%b%b%b exp 0",
                     c_in_ready, c_wr_en, c_wr_addr, c_wr_data,
                     c_cpu_hold, c_busy, c_done, c_err);
        end
        repeat (3) step(1'b0, 1'b1, 8'($urandom));
        checks++;
        if (obs_q.size() != 3 || obs_q != exp_q) begin
            errors++;
            $display("FAIL abort_writes got %0d writes exp 3 matching",
                     obs_q.size());
        end
        begin_session(0);
        for (int i = 0; i < 17; i++) step(1'b0, 1'b1, 8'($urandom));
        drain("restart");
    endtask

    task automatic test_start_reset();
        sel = 0;
        reset = 1'b1;
        start = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        start = 1'b0;
        repeat (2) begin
            checks++;
            if (c_busy !== 1'b0 || c_cpu_hold !== 1'b0 || c_in_ready !== 1'b0) begin
                errors++;
                $display("FAIL start_reset got %b%b%b exp 000",
                         c_busy, c_cpu_hold, c_in_ready);
            end
            step(1'b0, 1'b0, 8'h00);
        end
    endtask

    task automatic test_checksum();
        begin_session(2);
        step(1'b0, 1'b1, 8'h10);
        step(1'b0, 1'b1, 8'h20);
        step(1'b0, 1'b1, 8'hD0);
        drain("cksum_good");
        begin_session(2);
        step(1'b0, 1'b1, 8'h10);
        step(1'b0, 1'b1, 8'h20);
        step(1'b0, 1'b1, 8'hD1);
        drain("cksum_bad");
        checks++;
        if (c_err !== CK[0]) begin
            errors++;
            $display("FAIL err_sticky got %b exp %b", c_err, CK[0]);
        end
        begin_session(2);
        checks++;
        if (c_err !== 1'b0) begin
            errors++;
            $display("FAIL err_clear_on_start got %b exp 0", c_err);
        end
        for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 8'($urandom));
        drain("cksum_random");
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog timeout at cyc %0d", cyc);
        $fatal(1);
    end

    initial begin
        test_reset();
        test_back_to_back();
        test_gaps();
        test_start_ignored();
        test_random();
        test_abort();
        test_start_reset();
        test_checksum();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
